// File: rtl/radix_4_divider_if.sv
// rtl/radix_4_divider_if.sv - request/result bundle for the radix-4 divider
interface radix_4_divider_if;
    logic        start;
    logic [15:0] dividend_value;
    logic [7:0]  divisor_value;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        ready;
    logic        busy;
    logic        div_by_zero;

    modport master (
        output start, dividend_value, divisor_value,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    modport slave (
        input  start, dividend_value, divisor_value,
        output quotient, remainder, ready, busy, div_by_zero
    );
endinterface

// File: rtl/radix_4_divider.sv
// rtl/radix_4_divider.sv - 16/8 unsigned restoring divider, two quotient bits per cycle
module radix_4_divider (
    input  logic              clk_i,
    input  logic              rst_ni,
    radix_4_divider_if.slave  div_if
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [9:0]  rem_q, rem_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] quo_shift_q, quo_shift_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        dbz_q, dbz_d;

    logic [9:0]  r_prime, d1, d2, d3, sub_val, r_next;
    logic [1:0]  digit;

    // The remainder is always below the divisor, so its low 8 bits plus the next dividend pair form R'.
    always_comb begin
        r_prime = {rem_q[7:0], dvd_q[15:14]};
        d1      = {2'b00, dvs_q};
        d2      = {1'b0, dvs_q, 1'b0};
        d3      = d1 + d2;
        if (r_prime >= d3) begin
            digit   = 2'd3;
            sub_val = d3;
        end else if (r_prime >= d2) begin
            digit   = 2'd2;
            sub_val = d2;
        end else if (r_prime >= d1) begin
            digit   = 2'd1;
            sub_val = d1;
        end else begin
            digit   = 2'd0;
            sub_val = 10'd0;
        end
        r_next = r_prime - sub_val;
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quo_shift_d = quo_shift_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (div_if.start) begin
                    dvd_d       = div_if.dividend_value;
                    dvs_d       = div_if.divisor_value;
                    rem_d       = 10'd0;
                    cnt_d       = 3'd0;
                    quo_shift_d = 16'd0;
                    ready_d     = 1'b0;
                    dbz_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_CALC;
                end
            end
            S_CALC: begin
                if (dvs_q == 8'd0) begin
                    quotient_d  = 16'hFFFF;
                    remainder_d = dvd_q[7:0];
                    dbz_d       = 1'b1;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    rem_d       = r_next;
                    quo_shift_d = {quo_shift_q[13:0], digit};
                    dvd_d       = {dvd_q[13:0], 2'b00};
                    cnt_d       = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        quotient_d  = {quo_shift_q[13:0], digit};
                        remainder_d = r_next[7:0];
                        ready_d     = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            dvd_q       <= 16'd0;
            dvs_q       <= 8'd0;
            rem_q       <= 10'd0;
            cnt_q       <= 3'd0;
            quo_shift_q <= 16'd0;
            quotient_q  <= 16'd0;
            remainder_q <= 8'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quo_shift_q <= quo_shift_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            dbz_q       <= dbz_d;
        end
    end

    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.ready       = ready_q;
    assign div_if.busy        = busy_q;
    assign div_if.div_by_zero = dbz_q;
endmodule

// File: tb/tb_radix_4_divider.sv
// tb/tb_radix_4_divider.sv - self-checking bench for radix_4_divider
module tb_radix_4_divider;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    radix_4_divider_if ifc ();

    radix_4_divider dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .div_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (ifc.ready && ifc.busy) begin
                n_fail++;
                $display("FAIL ready_busy_exclusive actual=11 required=not both");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready after an accepting edge; operands are scrambled meanwhile.
    task automatic wait_result(input string name, input int already, input int exp_lat,
                               input logic [15:0] exp_q, input logic [7:0] exp_r, input logic exp_dbz);
        int edges;
        edges = already;
        while (!ifc.ready && edges < 20) begin
            ifc.dividend_value = 16'($urandom);
            ifc.divisor_value  = 8'($urandom);
            tick();
            edges++;
        end
        check({name, "_latency"}, edges, exp_lat);
        check({name, "_quotient"}, ifc.quotient, exp_q);
        check({name, "_remainder"}, ifc.remainder, exp_r);
        check({name, "_dbz"}, ifc.div_by_zero, exp_dbz);
        check({name, "_busy_done"}, ifc.busy, 0);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        ifc.start          = 1'b1;
        ifc.dividend_value = a;
        ifc.divisor_value  = b;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] exp_q, input logic [7:0] exp_r, input logic exp_dbz);
        start_op(a, b);
        check({name, "_accept"}, {ifc.busy, ifc.ready}, 2'b10);
        wait_result(name, 0, (b == 8'd0) ? 1 : 8, exp_q, exp_r, exp_dbz);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] hold_q;
        logic [7:0]  hold_r;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        ifc.start          = 1'b0;
        ifc.dividend_value = 16'd0;
        ifc.divisor_value  = 8'd0;

        vecs[0] = '{dvd: 16'd100,   dvs: 8'd7,   q: 16'd14,    r: 8'd2,   dbz: 1'b0};
        vecs[1] = '{dvd: 16'd65535, dvs: 8'd255, q: 16'd257,   r: 8'd0,   dbz: 1'b0};
        vecs[2] = '{dvd: 16'd5,     dvs: 8'd9,   q: 16'd0,     r: 8'd5,   dbz: 1'b0};
        vecs[3] = '{dvd: 16'd1000,  dvs: 8'd0,   q: 16'hFFFF,  r: 8'hE8,  dbz: 1'b1};
        vecs[4] = '{dvd: 16'd65535, dvs: 8'd1,   q: 16'd65535, r: 8'd0,   dbz: 1'b0};
        vecs[5] = '{dvd: 16'd0,     dvs: 8'd13,  q: 16'd0,     r: 8'd0,   dbz: 1'b0};
        vecs[6] = '{dvd: 16'd65534, dvs: 8'd255, q: 16'd256,   r: 8'd254, dbz: 1'b0};
        vecs[7] = '{dvd: 16'd200,   dvs: 8'd3,   q: 16'd66,    r: 8'd2,   dbz: 1'b0};

        #3;
        check("reset_outputs", {ifc.quotient, ifc.remainder, ifc.ready, ifc.busy, ifc.div_by_zero}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz);

        hold_q = ifc.quotient;
        hold_r = ifc.remainder;
        for (int i = 0; i < 3; i++) begin
            ifc.dividend_value = 16'($urandom);
            ifc.divisor_value  = 8'($urandom);
            tick();
        end
        check("done_stable", {ifc.quotient, ifc.remainder, ifc.ready, ifc.div_by_zero},
              {16'd66, 8'd2, 1'b1, 1'b0});
        check("done_hold_match", {ifc.quotient, ifc.remainder}, {hold_q, hold_r});

        start_op(16'd100, 8'd7);
        tick();
        tick();
        ifc.start          = 1'b1;
        ifc.dividend_value = 16'd200;
        ifc.divisor_value  = 8'd3;
        tick();
        ifc.start = 1'b0;
        wait_result("restart_in_calc", 3, 8, 16'd14, 8'd2, 1'b0);
        run_op("restart_from_done", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0);

        start_op(16'd65535, 8'd1);
        for (int i = 0; i < 4; i++) tick();
        check("pre_abort_busy", ifc.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", {ifc.quotient, ifc.remainder, ifc.ready, ifc.busy, ifc.div_by_zero}, 0);
        tick();
        check("abort_held", {ifc.quotient, ifc.remainder, ifc.ready, ifc.busy}, 0);
        rst_n = 1'b1;
        tick();
        check("abort_idle", {ifc.ready, ifc.busy}, 0);
        run_op("after_abort", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            run_op("rand", a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/radix_4_divider.md
RADIX_4_DIVIDER -- requirements
Module: radix_4_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clock).
REQ-004 start  input  1  request to begin a division; sampled on rising edge.
REQ-005 dividend_value  input  16  unsigned dividend.
REQ-006 divisor_value  input  8  unsigned divisor.
REQ-007 quotient  output  16  unsigned quotient, registered.
REQ-008 remainder  output  8  unsigned remainder, registered.
REQ-009 ready  output  1  high when quotient/remainder hold a completed result.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 div_by_zero  output  1  high with ready when the latched divisor was 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge SHALL latch dividend_value and divisor_value into internal registers, clear ready and div_by_zero, clear the 10-bit partial remainder and 3-bit iteration counter, set busy, and enter CALC.
REQ-014 Operand inputs SHALL be ignored at all edges other than the accepting edge; they may change freely during CALC.
REQ-015 start=1 while in CALC SHALL be ignored, with no effect on the running operation.
REQ-016 Each CALC cycle SHALL retire two dividend bits, MSB pair first: R' = {R[7:0], next two dividend bits} (10 bits).
REQ-017 Per cycle, the quotient digit q SHALL be the largest of 0..3 with q*divisor <= R', computed by parallel comparison against d, 2d, 3d (10-bit); R <= R' - q*divisor.
REQ-018 The digit q SHALL be shifted into the quotient shift register at the LSB end, two bits per cycle.
REQ-019 CALC SHALL last exactly 8 cycles (counter 0..7); at the 8th CALC edge the FSM SHALL enter DONE, load quotient and remainder=R[7:0], set ready=1, clear busy.
REQ-020 Latency: ready SHALL be observable high exactly 8 clock edges after the start-accepting edge.
REQ-021 If the latched divisor is 0, the FSM SHALL skip iteration and enter DONE at the next edge with quotient=16'hFFFF, remainder=latched dividend[7:0], div_by_zero=1, ready=1, busy=0.
REQ-022 In DONE, ready, quotient, remainder, and div_by_zero SHALL remain stable until a new start is accepted.
REQ-023 The invariants remainder < divisor and quotient*divisor + remainder = dividend SHALL hold for every nonzero divisor.
REQ-024 ready and busy SHALL never both be high.

Reset
REQ-025 On reset=0: state=IDLE; quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0; internal counters/registers cleared.
REQ-026 Reset asserted mid-CALC SHALL abort the operation immediately; no partial result appears on outputs.
REQ-027 After reset release, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-028 dividend=100, divisor=7, start pulse -> ready high 8 edges later; quotient=14, remainder=2, div_by_zero=0.
REQ-029 dividend=65535, divisor=255 -> quotient=257, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-030 dividend=1000, divisor=0 -> ready after 1 edge; quotient=16'hFFFF, remainder=8'hE8, div_by_zero=1.
REQ-031 Start 100/7, reassert start with 200/3 at CALC cycle 3 -> second start ignored; result 14 r 2; then start from DONE with 200/3 -> 66 r 2.
REQ-032 Start 65535/1, assert reset=0 asynchronously at CALC cycle 4 -> outputs go to 0 immediately, state IDLE; subsequent 100/7 completes correctly.
REQ-033 Random sweep of at least 10,000 operand pairs (divisor nonzero) -> REQ-023 invariant and 8-edge latency hold on every operation.
